sa_operand_feeder: RTL and testbench
====================================

SA_OPERAND_FEEDER -- requirements
Module: sa_operand_feeder

Interface
REQ-001 Parameter X, default 3: rows of the left operand.
REQ-002 Parameter N, default 3: shared inner dimension.
REQ-003 Parameter Y, default 3: columns of the right operand.
REQ-004 Parameter IN_LEN, default 4: operand word width.
REQ-005 Parameter ADDR_WIDTH, default 4: operand memory address width.
REQ-006 Parameter START_GAP, default 2: idle cycles between the last valid word and SA_start.
REQ-007 Port clk, input, 1: single clock, rising edge.
REQ-008 Port sys_rst, input, 1: synchronous, active-high reset.
REQ-009 Port start, input, 1: request one load-and-fire pass.
REQ-010 Port x_base and y_base, input, ADDR_WIDTH each: start addresses, latched when start is accepted.
REQ-011 Port x_rd_en and y_rd_en, output, 1 each: operand memory read enables.
REQ-012 Port x_rd_addr and y_rd_addr, output, ADDR_WIDTH each: read addresses.
REQ-013 Port x_rd_data and y_rd_data, input, IN_LEN each: read data, valid one cycle after rd_en.
REQ-014 Port Xin_val and Xin_data, output, 1 and IN_LEN [IN_LEN:1]: left-operand stream to the systolic array.
REQ-015 Port Yin_val and Yin_data, output, 1 and IN_LEN [IN_LEN:1]: right-operand stream.
REQ-016 Port SA_start, output, 1: single-cycle compute trigger.
REQ-017 Port busy and done, output, 1 each: pass in progress, and a one-cycle completion pulse.

Function
REQ-018 FSM states SHALL be IDLE -> FETCH -> DRAIN -> GAP -> FIRE -> DONE -> IDLE.
REQ-019 start SHALL be accepted only in IDLE; start in any other state (DONE included) SHALL be ignored.
REQ-020 FETCH SHALL assert x_rd_en for X*N consecutive cycles at x_base, x_base+1, ..., and y_rd_en for Y*N consecutive cycles at y_base, ...; both streams start in the same cycle.
REQ-021 Address increment SHALL wrap modulo 2^ADDR_WIDTH.
REQ-022 Xin_val/Xin_data SHALL be registered from x_rd_en delayed one cycle and x_rd_data, so the first Xin_val occurs 3 cycles after the start cycle; the same SHALL apply to the Y stream.
REQ-023 Xin_data/Yin_data SHALL be 0 in every cycle in which the matching val is low.
REQ-024 DRAIN SHALL last until both val signals have fallen; a shorter stream SHALL deassert its val early and independently.
REQ-025 GAP SHALL hold for exactly START_GAP cycles; START_GAP=0 places SA_start in the cycle immediately after the last val cycle.
REQ-026 SA_start SHALL be high for exactly one cycle (FIRE), and done SHALL pulse in the following cycle (DONE).
REQ-027 busy SHALL be high from the cycle after start acceptance through the DONE cycle inclusive.
REQ-028 Counters SHALL be sized ceil(log2(max(X,Y)*N+1)) bits; rd_en SHALL never exceed its word count.

Reset
REQ-029 On sys_rst, at the next clock edge every output SHALL be 0 and the FSM SHALL be in IDLE, including mid-pass; no SA_start or done SHALL be emitted for an aborted pass.
REQ-030 start sampled in the same cycle as sys_rst SHALL be ignored.

Verification
REQ-031 Defaults, x_base=0, y_base=0, memories hold 1..9, start pulse in cycle 0 -> Xin_val and Yin_val high in cycles 3-11 with data 1..9; SA_start in cycle 14; done in cycle 15; busy high in cycles 1-15.
REQ-032 X=2, Y=3, N=3 -> Xin_val high for 6 cycles and Yin_val for 9, both starting together; SA_start START_GAP cycles after the last Yin_val.
REQ-033 x_base=14 with ADDR_WIDTH=4 -> x_rd_addr sequence 14, 15, 0, 1, ..., 6.
REQ-034 start re-pulsed during FETCH and during DONE -> ignored; exactly one SA_start pulse.
REQ-035 sys_rst asserted at cycle 6 of a pass -> all outputs 0 from cycle 7; no SA_start; a new start is accepted normally.
REQ-036 START_GAP=0 -> SA_start in the cycle directly after the last val cycle.

Source files
------------

// File: rtl/sa_operand_feeder.sv
// rtl/sa_operand_feeder.sv - fetches X and Y operand words from memory, streams them to a
// systolic array, then fires a one-cycle SA_start after a fixed idle gap.
module sa_operand_feeder #(
  parameter int X          = 3,
  parameter int N          = 3,
  parameter int Y          = 3,
  parameter int IN_LEN     = 4,
  parameter int ADDR_WIDTH = 4,
  parameter int START_GAP  = 2
) (
  input  logic                  clk,
  input  logic                  sys_rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] x_base,
  input  logic [ADDR_WIDTH-1:0] y_base,
  output logic                  x_rd_en,
  output logic                  y_rd_en,
  output logic [ADDR_WIDTH-1:0] x_rd_addr,
  output logic [ADDR_WIDTH-1:0] y_rd_addr,
  input  logic [IN_LEN-1:0]     x_rd_data,
  input  logic [IN_LEN-1:0]     y_rd_data,
  output logic                  Xin_val,
  output logic [IN_LEN:1]       Xin_data,
  output logic                  Yin_val,
  output logic [IN_LEN:1]       Yin_data,
  output logic                  SA_start,
  output logic                  busy,
  output logic                  done
);

  localparam int XW = X * N;
  localparam int YW = Y * N;
  localparam int MW = (XW > YW) ? XW : YW;
  localparam int CW = $clog2(MW + 1);
  localparam int GW = (START_GAP > 0) ? $clog2(START_GAP + 1) : 1;
  localparam logic [CW-1:0] X_WORDS  = CW'(XW);
  localparam logic [CW-1:0] Y_WORDS  = CW'(YW);
  localparam logic [CW-1:0] CNT_LAST = CW'(MW - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'((START_GAP > 0) ? START_GAP - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DRAIN, S_GAP, S_FIRE, S_DONE
  } state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [GW-1:0]         gap_q, gap_d;
  logic [ADDR_WIDTH-1:0] x_addr_q, x_addr_d;
  logic [ADDR_WIDTH-1:0] y_addr_q, y_addr_d;
  // pend marks a read issued last cycle whose data is on rd_data now
  logic                  x_pend_q, x_pend_d;
  logic                  y_pend_q, y_pend_d;
  logic                  xin_val_q, xin_val_d;
  logic                  yin_val_q, yin_val_d;
  logic [IN_LEN:1]       xin_data_q, xin_data_d;
  logic [IN_LEN:1]       yin_data_q, yin_data_d;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    gap_d      = gap_q;
    x_addr_d   = x_addr_q;
    y_addr_d   = y_addr_q;
    x_rd_en    = 1'b0;
    y_rd_en    = 1'b0;
    xin_val_d  = x_pend_q;
    yin_val_d  = y_pend_q;
    xin_data_d = x_pend_q ? x_rd_data : '0;
    yin_data_d = y_pend_q ? y_rd_data : '0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_FETCH;
          cnt_d    = '0;
          x_addr_d = x_base;
          y_addr_d = y_base;
        end
      end
      S_FETCH: begin
        // the shorter stream simply stops reading once its word count is reached
        x_rd_en = (cnt_q < X_WORDS);
        y_rd_en = (cnt_q < Y_WORDS);
        if (x_rd_en) x_addr_d = x_addr_q + 1'b1;
        if (y_rd_en) y_addr_d = y_addr_q + 1'b1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (!x_pend_q && !y_pend_q) begin
          state_d = (START_GAP == 0) ? S_FIRE : S_GAP;
          gap_d   = '0;
        end
      end
      S_GAP: begin
        if (gap_q == GAP_LAST) state_d = S_FIRE;
        else                   gap_d   = gap_q + 1'b1;
      end
      S_FIRE:  state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    x_pend_d = x_rd_en;
    y_pend_d = y_rd_en;
  end

  always_ff @(posedge clk) begin
    if (sys_rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      gap_q      <= '0;
      x_addr_q   <= '0;
      y_addr_q   <= '0;
      x_pend_q   <= 1'b0;
      y_pend_q   <= 1'b0;
      xin_val_q  <= 1'b0;
      yin_val_q  <= 1'b0;
      xin_data_q <= '0;
      yin_data_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      gap_q      <= gap_d;
      x_addr_q   <= x_addr_d;
      y_addr_q   <= y_addr_d;
      x_pend_q   <= x_pend_d;
      y_pend_q   <= y_pend_d;
      xin_val_q  <= xin_val_d;
      yin_val_q  <= yin_val_d;
      xin_data_q <= xin_data_d;
      yin_data_q <= yin_data_d;
    end
  end

  assign x_rd_addr = x_addr_q;
  assign y_rd_addr = y_addr_q;
  assign Xin_val   = xin_val_q;
  assign Yin_val   = yin_val_q;
  assign Xin_data  = xin_data_q;
  assign Yin_data  = yin_data_q;
  assign SA_start  = (state_q == S_FIRE);
  assign done      = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_sa_operand_feeder.sv
// tb/tb_sa_operand_feeder.sv - scoreboard bench for sa_operand_feeder, two parameter sets
// (3x3x3 with gap 2, and 2x3x3 with gap 0) sharing one clock.
module tb_sa_operand_feeder;

  typedef struct {
    int c;
    int v;
  } ev_t;

  localparam int XNW[2] = '{9, 6};
  localparam int YNW[2] = '{9, 9};
  localparam int GP[2]  = '{2, 0};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       rst[2], start[2];
  logic [3:0] xb[2], yb[2];
  logic       xen[2], yen[2];
  logic [3:0] xa[2], ya[2], xd[2], yd[2];
  logic       xv[2], yv[2];
  logic [4:1] xo[2], yo[2];
  logic       fire[2], busy[2], done[2];

  logic [3:0] mem_x[16], mem_y[16];

  ev_t q[2][4][$];
  int  fire_at[2], busy_lo[2], busy_hi[2];
  int  errs = 0, checks = 0;
  bit  mon_en = 1'b0;
  string sn[4] = '{"x_rd_addr", "y_rd_addr", "Xin_data", "Yin_data"};

  for (genvar g = 0; g < 2; g++) begin : g_dut
    sa_operand_feeder #(
      .X(g == 0 ? 3 : 2), .N(3), .Y(3), .IN_LEN(4), .ADDR_WIDTH(4),
      .START_GAP(g == 0 ? 2 : 0)
    ) u_dut (
      .clk(clk), .sys_rst(rst[g]), .start(start[g]),
      .x_base(xb[g]), .y_base(yb[g]),
      .x_rd_en(xen[g]), .y_rd_en(yen[g]),
      .x_rd_addr(xa[g]), .y_rd_addr(ya[g]),
      .x_rd_data(xd[g]), .y_rd_data(yd[g]),
      .Xin_val(xv[g]), .Xin_data(xo[g]),
      .Yin_val(yv[g]), .Yin_data(yo[g]),
      .SA_start(fire[g]), .busy(busy[g]), .done(done[g])
    );
  end

  // operand memories: one-cycle read latency, garbage on the bus when not reading
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      xd[k] <= xen[k] ? mem_x[xa[k]] : 4'($urandom);
      yd[k] <= yen[k] ? mem_y[ya[k]] : 4'($urandom);
    end
  end

  task automatic chk(input bit ok, input string nm, input int act, input int exp);
    checks++;
    if (!ok) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic model_start(input int k, input int c);
    int len;
    len = (XNW[k] > YNW[k]) ? XNW[k] : YNW[k];
    for (int i = 0; i < XNW[k]; i++) begin
      q[k][0].push_back('{c + 1 + i, (int'(xb[k]) + i) % 16});
      q[k][2].push_back('{c + 3 + i, int'(mem_x[(int'(xb[k]) + i) % 16])});
    end
    for (int i = 0; i < YNW[k]; i++) begin
      q[k][1].push_back('{c + 1 + i, (int'(yb[k]) + i) % 16});
      q[k][3].push_back('{c + 3 + i, int'(mem_y[(int'(yb[k]) + i) % 16])});
    end
    fire_at[k] = c + 3 + len + GP[k];
    busy_lo[k] = c + 1;
    busy_hi[k] = fire_at[k] + 1;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      for (int k = 0; k < 2; k++) begin
        for (int s = 0; s < 4; s++) begin
          bit en, exp_now;
          int v;
          ev_t e;
          case (s)
            0:       begin en = xen[k]; v = int'(xa[k]); end
            1:       begin en = yen[k]; v = int'(ya[k]); end
            2:       begin en = xv[k];  v = int'(xo[k]); end
            default: begin en = yv[k];  v = int'(yo[k]); end
          endcase
          while (q[k][s].size() > 0 && q[k][s][0].c < cyc) void'(q[k][s].pop_front());
          exp_now = (q[k][s].size() > 0) && (q[k][s][0].c == cyc);
          chk(en == exp_now, $sformatf("dut%0d %s valid", k, sn[s]), int'(en), int'(exp_now));
          if (exp_now) begin
            e = q[k][s].pop_front();
            if (en) chk(v == e.v, $sformatf("dut%0d %s value", k, sn[s]), v, e.v);
          end else if (s >= 2 && !en) begin
            chk(v == 0, $sformatf("dut%0d %s idle zero", k, sn[s]), v, 0);
          end
        end
        chk(fire[k] == (cyc == fire_at[k]), $sformatf("dut%0d SA_start", k),
            int'(fire[k]), int'(cyc == fire_at[k]));
        chk(done[k] == (cyc == fire_at[k] + 1), $sformatf("dut%0d done", k),
            int'(done[k]), int'(cyc == fire_at[k] + 1));
        chk(busy[k] == (cyc >= busy_lo[k] && cyc <= busy_hi[k]), $sformatf("dut%0d busy", k),
            int'(busy[k]), int'(cyc >= busy_lo[k] && cyc <= busy_hi[k]));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input int k, input string nm);
    logic [22:0] o;
    o = {xen[k], yen[k], xa[k], ya[k], xv[k], yv[k], xo[k], yo[k], fire[k], busy[k], done[k]};
    chk(o == '0, $sformatf("dut%0d %s", k, nm), int'(o), 0);
  endtask

  task automatic pulse_start(input int k);
    start[k] = 1'b1;
    if (!rst[k] && cyc > busy_hi[k]) model_start(k, cyc);
    step();
    start[k] = 1'b0;
    xb[k] = 4'($urandom);
    yb[k] = 4'($urandom);
  endtask

  task automatic wait_until(input int c);
    int lim = 300;
    while (cyc < c && lim > 0) begin
      step();
      lim--;
    end
    chk(lim > 0, "wait bound", cyc, c);
  endtask

  task automatic wait_idle(input int k);
    wait_until(busy_hi[k] + 2);
  endtask

  task automatic rand_mem();
    for (int i = 0; i < 16; i++) begin
      mem_x[i] = 4'($urandom);
      mem_y[i] = 4'($urandom);
    end
  endtask

  initial begin
    int s;
    for (int k = 0; k < 2; k++) begin
      rst[k] = 1'b1; start[k] = 1'b0; xb[k] = '0; yb[k] = '0;
      fire_at[k] = -10; busy_lo[k] = 0; busy_hi[k] = -1;
    end
    for (int i = 0; i < 16; i++) begin
      mem_x[i] = (i < 9) ? 4'(i + 1) : 4'd0;
      mem_y[i] = (i < 9) ? 4'(i + 1) : 4'd0;
    end
    repeat (3) @(posedge clk);
    #1;
    rst[0] = 1'b0; rst[1] = 1'b0;
    chk_zero(0, "reset outputs");
    chk_zero(1, "reset outputs");
    mon_en = 1'b1;

    // default pass, bases 0, data 1..9
    pulse_start(0); wait_idle(0);
    xb[1] = '0; yb[1] = '0;
    pulse_start(1); wait_idle(1);

    // address wrap from x_base=14
    xb[0] = 4'd14; yb[0] = 4'd3;
    pulse_start(0); wait_idle(0);

    // restarts during FETCH and DONE are ignored
    rand_mem();
    s = cyc;
    pulse_start(0);
    wait_until(s + 3); pulse_start(0);
    wait_until(fire_at[0] + 1); pulse_start(0);
    wait_idle(0);

    // reset in cycle 6 of a pass aborts it
    s = cyc;
    pulse_start(0);
    wait_until(s + 6);
    rst[0] = 1'b1;
    step();
    rst[0] = 1'b0;
    for (int i = 0; i < 4; i++) q[0][i].delete();
    fire_at[0] = -10;
    busy_hi[0] = cyc - 1;
    chk_zero(0, "mid-pass reset outputs");
    repeat (20) step();
    pulse_start(0); wait_idle(0);

    // start coinciding with reset is dropped
    rst[1] = 1'b1; start[1] = 1'b1;
    step();
    rst[1] = 1'b0; start[1] = 1'b0;
    step();
    chk(busy[1] == 1'b0, "dut1 start under reset", int'(busy[1]), 0);
    repeat (20) step();

    for (int it = 0; it < 8; it++) begin
      int k;
      k = int'($urandom_range(0, 1));
      rand_mem();
      xb[k] = 4'($urandom); yb[k] = 4'($urandom);
      pulse_start(k);
      wait_idle(k);
    end

    repeat (3) step();
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 4; i++)
        chk(q[k][i].size() == 0, $sformatf("dut%0d %s leftover", k, sn[i]), q[k][i].size(), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
